// File: rtl/line_window_stream.sv
`default_nettype none
// ============================================================================
// Module   : line_window_stream
// Function : Buffers ROWS image rows from a pixel stream and presents a
//            sliding ROWS x WIN window; a staging row prefetches the next row.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_stream #(
    parameter int PIXEL_W = 24,
    parameter int ROWS    = 3,
    parameter int WIN     = 3,
    parameter int COLS    = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         flush,
    input  logic                         start_prime,
    input  logic                         start_row,
    input  logic [PIXEL_W-1:0]           in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         win_advance,
    output logic [ROWS*WIN*PIXEL_W-1:0]  window_data,
    output logic                         window_valid,
    output logic [$clog2(COLS)-1:0]      window_col,
    output logic                         last_window,
    output logic                         load_done,
    output logic                         busy
);

    localparam int NWIN = COLS - WIN + 1;
    localparam int CW   = $clog2(COLS);
    localparam int RPW  = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_FILL = 2'd1,
        L_FULL = 2'd2
    } load_state_t;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } win_state_t;

    load_state_t      r_lstate, w_lstate_nxt;
    win_state_t       r_wstate, w_wstate_nxt;
    logic [CW-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [RPW-1:0]   r_rows_pending, w_rows_pending_nxt;
    logic [CW-1:0]    r_col, w_col_nxt;
    logic             r_load_done;
    logic             w_beat;
    logic             w_commit;
    logic             w_commit_last;

    logic [PIXEL_W-1:0] r_line    [ROWS][COLS];
    logic [PIXEL_W-1:0] r_staging [COLS];

    always_comb begin
        w_lstate_nxt       = r_lstate;
        w_wstate_nxt       = r_wstate;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_rows_pending_nxt = r_rows_pending;
        w_col_nxt          = r_col;
        w_beat             = 1'b0;
        w_commit           = 1'b0;
        w_commit_last      = 1'b0;

        case (r_lstate)
            L_IDLE: begin
                if (start_prime) begin
                    w_lstate_nxt       = L_FILL;
                    w_rows_pending_nxt = RPW'(ROWS);
                end else if (start_row) begin
                    w_lstate_nxt       = L_FILL;
                    w_rows_pending_nxt = RPW'(1);
                end
            end
            L_FILL: begin
                if (in_valid) begin
                    w_beat = 1'b1;
                    if (r_beat_cnt == CW'(COLS - 1)) begin
                        w_lstate_nxt   = L_FULL;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            L_FULL: begin
                // Holding here while windows are consumed is the prefetch.
                if (r_wstate == W_IDLE) begin
                    w_commit           = 1'b1;
                    w_rows_pending_nxt = r_rows_pending - 1'b1;
                    if (r_rows_pending == RPW'(1)) begin
                        w_commit_last = 1'b1;
                        w_lstate_nxt  = L_IDLE;
                    end else begin
                        w_lstate_nxt  = L_FILL;
                    end
                end
            end
            default: w_lstate_nxt = L_IDLE;
        endcase

        case (r_wstate)
            W_IDLE: begin
                if (w_commit_last) begin
                    w_wstate_nxt = W_ACTIVE;
                    w_col_nxt    = '0;
                end
            end
            W_ACTIVE: begin
                if (win_advance) begin
                    if (r_col == CW'(NWIN - 1)) begin
                        w_wstate_nxt = W_IDLE;
                        w_col_nxt    = '0;
                    end else begin
                        w_col_nxt    = r_col + 1'b1;
                    end
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_lstate       <= L_IDLE;
            r_wstate       <= W_IDLE;
            r_beat_cnt     <= '0;
            r_rows_pending <= '0;
            r_col          <= '0;
            r_load_done    <= 1'b0;
        end else if (flush) begin
            r_lstate       <= L_IDLE;
            r_wstate       <= W_IDLE;
            r_beat_cnt     <= '0;
            r_rows_pending <= '0;
            r_col          <= '0;
            r_load_done    <= 1'b0;
        end else begin
            r_lstate       <= w_lstate_nxt;
            r_wstate       <= w_wstate_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_rows_pending <= w_rows_pending_nxt;
            r_col          <= w_col_nxt;
            r_load_done    <= w_commit_last;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_line[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                r_staging[c] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_line[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                r_staging[c] <= '0;
            end
        end else begin
            if (w_beat) begin
                r_staging[r_beat_cnt] <= in_data;
            end
            if (w_commit) begin
                for (int r = 0; r < ROWS - 1; r++) begin
                    r_line[r] <= r_line[r + 1];
                end
                r_line[ROWS - 1] <= r_staging;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar k = 0; k < WIN; k++) begin : g_tap
            logic [CW-1:0] w_sel;
            assign w_sel = r_col + CW'(k);
            assign window_data[((r * WIN) + k) * PIXEL_W +: PIXEL_W] = r_line[r][w_sel];
        end
    end

    assign in_ready     = (r_lstate == L_FILL);
    assign window_valid = (r_wstate == W_ACTIVE);
    assign window_col   = r_col;
    assign last_window  = (r_wstate == W_ACTIVE) && (r_col == CW'(NWIN - 1));
    assign load_done    = r_load_done;
    assign busy         = (r_lstate != L_IDLE) || (r_wstate == W_ACTIVE);

endmodule
`default_nettype wire

// File: doc/line_window_stream.md
Name: line_window_stream

Overview:
- Parametrised successor to the cartoonifier's 3-row read buffer.
- Collects ROWS image rows of COLS pixels each from a ready/valid pixel stream into a row store.
- Presents a ROWS x WIN pixel window to the filter datapath and slides it one column per filter completion.
- Adds double buffering: the next row is fetched into a staging row while the current windows are still being consumed.

Parameters:
PIXEL_W, 24, bits per pixel
ROWS, 3, rows held in the window, ≥2
WIN, 3, window width in pixels, 1 ≤ WIN ≤ COLS
COLS, 8, pixels per row segment; windows per segment NWIN = COLS-WIN+1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all state, counters and storage
start_prime  in  1  request a fill of all ROWS rows
start_row  in  1  request a fetch of one new row
in_data  in  PIXEL_W  pixel, left-most column first
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
win_advance  in  1  filter finished the current window
window_data  out  ROWS*WIN*PIXEL_W  current window
window_valid  out  1  window_data valid
window_col  out  $clog2(COLS)  left column of the current window
last_window  out  1  window_valid and window_col == NWIN-1
load_done  out  1  one-cycle pulse when the window becomes valid after a commit
busy  out  1  load side not L_IDLE or window side W_ACTIVE

Behaviour:
- Reset (n_rst=0, async) and flush (sync, overrides all other inputs):
  - all row and staging storage cleared to 0
  - both FSMs idle; counters cleared
  - all outputs 0
- Storage: line[0..ROWS-1], each COLS pixels; line[0] is the oldest (top) row, line[ROWS-1] the newest.
- Staging: one row of COLS pixels.
- Window packing: window_data[((r*WIN)+k)*PIXEL_W +: PIXEL_W] = line[r] pixel (window_col+k), for r in 0..ROWS-1 and k in 0..WIN-1. Combinational from the registers.
- Load FSM:
  - L_IDLE:
    - start_prime → L_FILL with rows_pending=ROWS.
    - Else start_row → L_FILL with rows_pending=1.
    - Both asserted: prime wins.
    - start_* outside L_IDLE is ignored.
  - L_FILL:
    - in_ready=1.
    - Each in_valid&in_ready beat writes staging[beat_cnt]; beat_cnt increments.
    - On beat COLS-1 → L_FULL, beat_cnt=0.
  - L_FULL:
    - in_ready=0.
    - Commit when the window FSM is W_IDLE (registered state): line[r]<=line[r+1], line[ROWS-1]<=staging; rows_pending decrements.
    - rows_pending becomes 0 → L_IDLE, the window FSM goes W_ACTIVE with window_col=0, and load_done pulses the following cycle (aligned with the first window_valid).
    - Otherwise → L_FILL.
    - While W_ACTIVE, L_FULL holds with no commit; this is how the staging row prefetches during filtering.
- Window FSM:
  - W_IDLE: window_valid=0; win_advance ignored.
  - W_ACTIVE: window_valid=1.
    - win_advance with window_col<NWIN-1 → window_col+1.
    - win_advance with window_col==NWIN-1 → W_IDLE, window_col=0.
- Latency:
  - The last beat accepted in cycle N gives L_FULL in N+1.
  - If W_IDLE in N+1, commit at the end of N+1; window_valid=1 and load_done=1 in N+2.
  - A final win_advance in cycle M with L_FULL pending: W_IDLE in M+1, commit at the end of M+1, new window_valid in M+2. There is exactly one invalid cycle between segments.
- Prime: ROWS sequential fill/commit rounds; window_valid rises only after the final commit.
- Row store contents persist across start_row; only the shift on commit changes them.
- in_valid while in_ready=0: data is not taken; the source must hold it.

Test Plan:
- Defaults; reset; start_prime; feed 24 beats with value = row*16+col (0x00..0x07, 0x10..0x17, 0x20..0x27), in_valid always 1 → in_ready low for 1 cycle after each 8th beat; load_done and window_valid at the 2nd cycle after beat 24; window_data row0 = 00,01,02; row1 = 10,11,12; row2 = 20,21,22; window_col=0.
- Pulse win_advance 5 times → window_col 1..5; at col 5 last_window=1 and window = 05..07/15..17/25..27; 6th pulse → window_valid=0.
- During the active window, start_row plus 8 beats 0x30..0x37 → in_ready drops after beat 8 and window data is unchanged. After the 6th win_advance, one invalid cycle, then window rows = 1x/2x/3x at col 0, with load_done pulse.
- start_prime and start_row in the same cycle → 24 beats are accepted (prime wins); start_row during L_FILL → ignored.
- Random in_valid gaps (50%) during prime → same window contents as the first scenario; beat count unaffected by idle cycles.
- Assert flush mid-prime (after beat 10) and async n_rst mid-active → all outputs 0 the next cycle; a new prime then behaves exactly as in the first scenario.
- Parameter sweep ROWS=5, WIN=5, COLS=16, PIXEL_W=8 → 12 windows per segment; packing checked at col 0 and col 11.
